alu_chrom_sequencer: RTL and testbench
======================================

Name: alu_chrom_sequencer

Overview:
Hardware stimulus sequencer that drives the ALU input interface according to one chromosome's settings. It issues a configured number of ALU transactions. Inter-transaction delay, opcode and operands are drawn from an internal LFSR, constrained by the chromosome's delay range and opcode-enable mask. It sits between the GA evaluation harness (START/DONE) and the ALU input port (ACT/ALU_RDY handshake). It replaces per-transaction software driving for long evolution runs.

Parameters:
DATA_WIDTH, 8, width of REG_A/REG_B/MEM/IMM
TRANS_CNT_WIDTH, 16, width of transaction counter and CFG_TRANS_COUNT
DELAY_WIDTH, 4, width of delay bounds and delay counter
LFSR_SEED, 32'hACE1_2012, LFSR reset value; must be non-zero

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  synchronous reset, active-low
START  in  1  one-cycle pulse; accepted only in IDLE
CFG_TRANS_COUNT  in  TRANS_CNT_WIDTH  transactions to issue; sampled on START
CFG_DELAY_MIN  in  DELAY_WIDTH  minimum idle cycles between transactions; sampled on START
CFG_DELAY_MAX  in  DELAY_WIDTH  maximum idle cycles; sampled on START
CFG_OP_MASK  in  16  bit i=1 enables opcode i; sampled on START
ALU_RDY  in  1  ALU can accept a transaction this cycle
ACT  out  1  transaction valid
OP  out  4  opcode
MOVI  out  2  operand-B source select
REG_A, REG_B, MEM, IMM  out  DATA_WIDTH each  operands
BUSY  out  1  high in any state other than IDLE
DONE  out  1  one-cycle pulse when the run completes
ERR  out  1  sticky; config rejected; cleared by next accepted START
TRANS_SENT  out  TRANS_CNT_WIDTH  transfers completed in current run

Behaviour:
- Reset (RST=0 at an edge): state IDLE. All outputs 0. LFSR loaded with LFSR_SEED. Reset mid-run aborts immediately, with no DONE pulse.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1. Advances every cycle the block is out of reset.
- FSM states: IDLE, DELAY, ISSUE, FIN.
- IDLE + START:
  - Latch the CFG_* inputs, clear TRANS_SENT, clear ERR.
  - If CFG_OP_MASK==0, or CFG_TRANS_COUNT==0, or CFG_DELAY_MAX<CFG_DELAY_MIN: set ERR=1, go to FIN.
  - Otherwise load the delay counter and go to DELAY.
- START outside IDLE is ignored.
- Delay value: d = MIN + (L[DELAY_WIDTH-1:0] mod (MAX-MIN+1)), where L is the LFSR value in the loading cycle.
- DELAY:
  - Counter decrements each cycle.
  - Leaving DELAY, capture the payload from the current LFSR value and go to ISSUE. This happens when the counter is 0 on entry/decrement; with d=0, DELAY lasts exactly 1 cycle.
- Payload capture:
  - OP = first enabled opcode scanning upward from L[11:8], wrapping 15 to 0.
  - MOVI = L[13:12]; value 3 maps to 0.
  - REG_A = L[DATA_WIDTH+13:14].
  - REG_B, MEM, IMM are taken from successive DATA_WIDTH slices of the rotated LFSR.
- ISSUE:
  - ACT=1. Payload held stable while ACT=1 and ALU_RDY=0.
  - A transfer happens on a cycle with ACT=1 and ALU_RDY=1; TRANS_SENT increments on that edge.
  - If TRANS_SENT+1==count, go to FIN; otherwise reload the delay counter and go to DELAY.
  - ACT drops the cycle after the transfer, giving at least 1 idle cycle between transactions.
- FIN: DONE=1 for one cycle, then IDLE. BUSY is high in FIN.
- TRANS_SENT saturates at all-ones; it cannot exceed the count by construction.
- ALU_RDY is ignored outside ISSUE.

Optional Feature:
- Macro ALU_SEQ_STATS_EN.
- When defined:
  - Adds output STALL_CNT (TRANS_CNT_WIDTH). It counts cycles in ISSUE with ALU_RDY=0, saturating.
  - Adds output DELAY_CNT (TRANS_CNT_WIDTH). It counts total DELAY-state cycles, saturating.
  - Both clear on reset and on accepted START, and hold after DONE.
- When undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset, then START with count=3, MIN=MAX=0, mask=16'h0001, ALU_RDY=1 → three ACT pulses, each with OP=0, separated by exactly 1 idle cycle; DONE pulses once; TRANS_SENT=3; ERR=0.
- count=1, mask=16'h0010, ALU_RDY held 0 for 5 cycles in ISSUE → ACT and the full payload stay stable for all 5 cycles; transfer occurs on the 6th cycle; STALL_CNT=5 when ALU_SEQ_STATS_EN is defined.
- count=100, MIN=2, MAX=5, ALU_RDY=1 → every gap between transfers is 3..6 cycles; TRANS_SENT=100; a single DONE pulse.
- mask=0, count=10 → ERR=1, DONE pulses 2 cycles after START, ACT never asserts; a following valid START clears ERR.
- MIN=6, MAX=2 → ERR=1 and no transactions. count=0 → ERR=1 and no transactions.
- Assert RST=0 mid-ISSUE with count=50 → next edge gives IDLE with all outputs 0 and no DONE; after release, START reproduces the same first OP/operands as the first run (LFSR re-seeded to LFSR_SEED).

Source files
------------

// File: rtl/alu_chrom_sequencer_if.sv
// ALU input-port bundle between the chromosome sequencer (master) and the ALU
// (slave).
// Handshake: the master raises ACT together with a payload (OP, MOVI, REG_A,
// REG_B, MEM, IMM). A transfer happens on every rising CLK edge where ACT and
// ALU_RDY are both high. While ACT=1 and ALU_RDY=0 the master holds ACT and the
// whole payload stable. ALU_RDY has no meaning while ACT=0.
interface alu_chrom_sequencer_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  ACT;
  logic [3:0]            OP;
  logic [1:0]            MOVI;
  logic [DATA_WIDTH-1:0] REG_A;
  logic [DATA_WIDTH-1:0] REG_B;
  logic [DATA_WIDTH-1:0] MEM;
  logic [DATA_WIDTH-1:0] IMM;
  logic                  ALU_RDY;

  modport master (
    output ACT, OP, MOVI, REG_A, REG_B, MEM, IMM,
    input  ALU_RDY
  );

  modport slave (
    input  ACT, OP, MOVI, REG_A, REG_B, MEM, IMM,
    output ALU_RDY
  );
endinterface

// File: rtl/alu_chrom_sequencer.sv
// alu_chrom_sequencer: issues CFG_TRANS_COUNT ALU transactions for one
// chromosome. Each transaction waits MIN..MAX idle cycles, then presents an
// opcode (restricted to CFG_OP_MASK) and operands drawn from a free-running
// 32-bit Galois LFSR (x^32+x^22+x^2+x+1).
// Optional build macro ALU_SEQ_STATS_EN adds STALL_CNT and DELAY_CNT outputs.
// state_dbg exposes the FSM state (0=IDLE 1=DELAY 2=ISSUE 3=FIN).
module alu_chrom_sequencer #(
  parameter int          DATA_WIDTH      = 8,
  parameter int          TRANS_CNT_WIDTH = 16,
  parameter int          DELAY_WIDTH     = 4,
  parameter logic [31:0] LFSR_SEED       = 32'hACE1_2012
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic [TRANS_CNT_WIDTH-1:0] CFG_TRANS_COUNT,
  input  logic [DELAY_WIDTH-1:0]     CFG_DELAY_MIN,
  input  logic [DELAY_WIDTH-1:0]     CFG_DELAY_MAX,
  input  logic [15:0]                CFG_OP_MASK,
  alu_chrom_sequencer_if.master      alu,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       ERR,
  output logic [1:0]                 state_dbg,
  output logic [TRANS_CNT_WIDTH-1:0] TRANS_SENT
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [TRANS_CNT_WIDTH-1:0] STALL_CNT,
  output logic [TRANS_CNT_WIDTH-1:0] DELAY_CNT
`endif
);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_ISSUE = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic [31:0]                lfsr;
  logic [TRANS_CNT_WIDTH-1:0] cnt_q;
  logic [DELAY_WIDTH-1:0]     min_q;
  logic [DELAY_WIDTH-1:0]     max_q;
  logic [15:0]                mask_q;
  logic [DELAY_WIDTH-1:0]     wait_cnt;

  logic [3:0]                 op_q;
  logic [1:0]                 movi_q;
  logic [DATA_WIDTH-1:0]      reg_a_q;
  logic [DATA_WIDTH-1:0]      reg_b_q;
  logic [DATA_WIDTH-1:0]      mem_q;
  logic [DATA_WIDTH-1:0]      imm_q;

  logic                       cfg_bad;
  logic                       start_ok;
  logic                       xfer;
  logic                       last_xfer;
  logic                       capture;
  logic [TRANS_CNT_WIDTH:0]   sent_inc;
  logic [DELAY_WIDTH-1:0]     delay_start;
  logic [DELAY_WIDTH-1:0]     delay_next;

  // d = lo + (l[DELAY_WIDTH-1:0] mod (hi-lo+1)); only used when hi >= lo.
  function automatic logic [DELAY_WIDTH-1:0] draw_delay(
    input logic [DELAY_WIDTH-1:0] lo,
    input logic [DELAY_WIDTH-1:0] hi,
    input logic [31:0]            l
  );
    logic [DELAY_WIDTH:0] span;
    logic [DELAY_WIDTH:0] off;
    span = {1'b0, hi} - {1'b0, lo} + (DELAY_WIDTH+1)'(1);
    off  = {1'b0, l[DELAY_WIDTH-1:0]} % span;
    return lo + off[DELAY_WIDTH-1:0];
  endfunction

  // First enabled opcode at or above 'first', wrapping 15 -> 0.
  function automatic logic [3:0] pick_op(
    input logic [15:0] mask,
    input logic [3:0]  first
  );
    logic [3:0] idx;
    logic [3:0] op;
    logic       found;
    op    = 4'd0;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = first + 4'(k);
      if (!found && mask[idx]) begin
        op    = idx;
        found = 1'b1;
      end
    end
    return op;
  endfunction

  // DATA_WIDTH bits of the LFSR starting at bit 'pos', wrapping past bit 31.
  function automatic logic [DATA_WIDTH-1:0] rot_slice(
    input logic [31:0] l,
    input int          pos
  );
    logic [DATA_WIDTH-1:0] s;
    logic [4:0]            idx;
    s = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      idx  = 5'(pos + j);
      s[j] = l[idx];
    end
    return s;
  endfunction

  assign cfg_bad     = (CFG_OP_MASK == 16'h0000) || (CFG_TRANS_COUNT == '0) ||
                       (CFG_DELAY_MAX < CFG_DELAY_MIN);
  assign start_ok    = (state == S_IDLE) && START;
  assign xfer        = (state == S_ISSUE) && alu.ALU_RDY;
  assign sent_inc    = {1'b0, TRANS_SENT} + (TRANS_CNT_WIDTH+1)'(1);
  assign last_xfer   = (sent_inc == {1'b0, cnt_q});
  assign capture     = (state == S_DELAY) && (wait_cnt == '0);
  assign delay_start = draw_delay(CFG_DELAY_MIN, CFG_DELAY_MAX, lfsr);
  assign delay_next  = draw_delay(min_q, max_q, lfsr);

  assign BUSY      = (state != S_IDLE);
  assign state_dbg = state;
  assign alu.ACT   = (state == S_ISSUE);
  assign alu.OP    = op_q;
  assign alu.MOVI  = movi_q;
  assign alu.REG_A = reg_a_q;
  assign alu.REG_B = reg_b_q;
  assign alu.MEM   = mem_q;
  assign alu.IMM   = imm_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (START) state_nx = cfg_bad ? S_FIN : S_DELAY;
      S_DELAY: if (wait_cnt == '0) state_nx = S_ISSUE;
      S_ISSUE: if (alu.ALU_RDY) state_nx = last_xfer ? S_FIN : S_DELAY;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Free-running LFSR, re-seeded by reset.
  always_ff @(posedge CLK) begin
    if (!RST)         lfsr <= LFSR_SEED;
    else if (lfsr[0]) lfsr <= (lfsr >> 1) ^ LFSR_TAPS;
    else              lfsr <= lfsr >> 1;
  end

  // Run control: config latch, delay countdown, transfer count, ERR and DONE.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      mask_q     <= '0;
      wait_cnt   <= '0;
      TRANS_SENT <= '0;
      ERR        <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      DONE <= (state == S_FIN);
      if (start_ok) begin
        cnt_q      <= CFG_TRANS_COUNT;
        min_q      <= CFG_DELAY_MIN;
        max_q      <= CFG_DELAY_MAX;
        mask_q     <= CFG_OP_MASK;
        TRANS_SENT <= '0;
        ERR        <= cfg_bad;
        if (!cfg_bad) wait_cnt <= delay_start;
      end else if ((state == S_DELAY) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - DELAY_WIDTH'(1);
      end else if (xfer) begin
        if (TRANS_SENT != '1) TRANS_SENT <= sent_inc[TRANS_CNT_WIDTH-1:0];
        if (!last_xfer) wait_cnt <= delay_next;
      end
    end
  end

  // Payload capture on the last DELAY cycle; held through ISSUE.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      op_q    <= '0;
      movi_q  <= '0;
      reg_a_q <= '0;
      reg_b_q <= '0;
      mem_q   <= '0;
      imm_q   <= '0;
    end else if (capture) begin
      op_q    <= pick_op(mask_q, lfsr[11:8]);
      movi_q  <= (lfsr[13:12] == 2'd3) ? 2'd0 : lfsr[13:12];
      reg_a_q <= lfsr[DATA_WIDTH+13:14];
      reg_b_q <= rot_slice(lfsr, DATA_WIDTH + 14);
      mem_q   <= rot_slice(lfsr, 2*DATA_WIDTH + 14);
      imm_q   <= rot_slice(lfsr, 3*DATA_WIDTH + 14);
    end
  end

`ifdef ALU_SEQ_STATS_EN
  // Saturating stall and delay-cycle statistics for the current run.
  always_ff @(posedge CLK) begin
    if (!RST || start_ok) begin
      STALL_CNT <= '0;
      DELAY_CNT <= '0;
    end else begin
      if ((state == S_ISSUE) && !alu.ALU_RDY && (STALL_CNT != '1))
        STALL_CNT <= STALL_CNT + TRANS_CNT_WIDTH'(1);
      if ((state == S_DELAY) && (DELAY_CNT != '1))
        DELAY_CNT <= DELAY_CNT + TRANS_CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_chrom_sequencer.sv
// Bench for alu_chrom_sequencer: directed runs checked cycle by cycle against a
// schedule-level model (absolute issue cycles, expected payload queue).
module tb_alu_chrom_sequencer;
  localparam int          DW   = 8;
  localparam int          TW   = 16;
  localparam int          LW   = 4;
  localparam logic [31:0] SEED = 32'hACE1_2012;
  localparam int          PW   = 4 + 2 + 4*DW;

  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_ISSUE = 2;
  localparam int P_FIN   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          rdy = 1'b1;
  logic [TW-1:0] cfg_count = '0;
  logic [LW-1:0] cfg_min = '0;
  logic [LW-1:0] cfg_max = '0;
  logic [15:0]   cfg_mask = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    state_dbg;
  logic [TW-1:0] sent;
`ifdef ALU_SEQ_STATS_EN
  logic [TW-1:0] stall_cnt;
  logic [TW-1:0] delay_cnt;
`endif

  alu_chrom_sequencer_if #(.DATA_WIDTH(DW)) alu ();
  assign alu.ALU_RDY = rdy;

  alu_chrom_sequencer #(
    .DATA_WIDTH(DW), .TRANS_CNT_WIDTH(TW), .DELAY_WIDTH(LW), .LFSR_SEED(SEED)
  ) dut (
    .CLK(clk), .RST(rst_n), .START(start),
    .CFG_TRANS_COUNT(cfg_count), .CFG_DELAY_MIN(cfg_min),
    .CFG_DELAY_MAX(cfg_max), .CFG_OP_MASK(cfg_mask),
    .alu(alu), .BUSY(busy), .DONE(done), .ERR(err),
    .state_dbg(state_dbg), .TRANS_SENT(sent)
`ifdef ALU_SEQ_STATS_EN
    , .STALL_CNT(stall_cnt), .DELAY_CNT(delay_cnt)
`endif
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d want < 100000", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- counters and check helper ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] mdl_step(input logic [31:0] l);
    // Galois form of x^32+x^22+x^2+x+1, shifting right.
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  function automatic int mdl_draw(input int lo, input int hi, input logic [31:0] l);
    return lo + (int'(l[3:0]) % (hi - lo + 1));
  endfunction

  function automatic logic [PW-1:0] mdl_decode(input logic [31:0] l, input logic [15:0] mask);
    logic [63:0]   ll;
    logic [3:0]    op;
    logic [1:0]    mv;
    logic [DW-1:0] a, b, m, im;
    int            c;
    op = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      c = (int'(l[11:8]) + k) % 16;
      if (mask[c]) op = 4'(c);
    end
    mv = (l[13:12] == 2'd3) ? 2'd0 : l[13:12];
    a  = l[21:14];
    ll = {l, l};
    b  = DW'(ll >> 22);
    m  = DW'(ll >> 30);
    im = DW'(ll >> 6);
    return {op, mv, a, b, m, im};
  endfunction

  logic [PW-1:0] exp_q[$];
  int            ph = P_IDLE;
  logic          m_valid = 1'b0;
  logic [31:0]   m_lfsr = '0;
  logic [PW-1:0] m_pay = '0;
  int            m_sent = 0;
  logic          m_err = 1'b0;
  logic          m_done = 1'b0;
  int            m_stall = 0;
  int            m_dly = 0;
  int            issue_at = 0;
  int            q_count = 0, q_min = 0, q_max = 0;
  logic [15:0]   q_mask = '0;

  // ---------------- monitor state ----------------
  int            xfer_cnt = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  int            prev_xfer_cyc = -1, act_rise_cyc = 0, last_xfer_cyc = 0;
  int            min_gap = 1000, max_gap = -1;
  logic          prev_act = 1'b0;
  logic [3:0]    op_q[$];
  logic          first_seen = 1'b0;
  logic [PW-1:0] first_obs = '0, first_exp = '0;

  function automatic logic [PW-1:0] dut_pay();
    return {alu.OP, alu.MOVI, alu.REG_A, alu.REG_B, alu.MEM, alu.IMM};
  endfunction

  task automatic check_cycle();
    logic [PW-1:0] e;
    int            g;
    chk("busy", busy, ph != P_IDLE);
    chk("act", alu.ACT, ph == P_ISSUE);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("trans_sent", sent, m_sent);
`ifdef ALU_SEQ_STATS_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("delay_cnt", delay_cnt, m_dly);
`endif
    if (alu.ACT) chk("payload", dut_pay(), m_pay);
    if (alu.ACT && !prev_act) begin
      act_rise_cyc = cyc;
      if (prev_xfer_cyc >= 0) begin
        g = cyc - prev_xfer_cyc - 1;
        if (g < min_gap) min_gap = g;
        if (g > max_gap) max_gap = g;
      end
    end
    if (alu.ACT && rdy) begin
      xfer_cnt++;
      prev_xfer_cyc = cyc;
      last_xfer_cyc = cyc;
      op_q.push_back(alu.OP);
      if (exp_q.size() == 0) begin
        chk("xfer_expected", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_payload", dut_pay(), e);
        if (!first_seen) begin
          first_seen = 1'b1;
          first_obs  = dut_pay();
          first_exp  = e;
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (start) start_cyc = cyc;
    prev_act = alu.ACT;
  endtask

  task automatic model_step();
    logic [31:0] l;
    logic        nx_done;
    l       = m_lfsr;
    nx_done = 1'b0;
    if (!rst_n) begin
      ph      = P_IDLE;
      m_sent  = 0;
      m_err   = 1'b0;
      m_pay   = '0;
      m_stall = 0;
      m_dly   = 0;
      m_lfsr  = SEED;
      exp_q.delete();
      m_valid = 1'b1;
    end else begin
      case (ph)
        P_IDLE: if (start) begin
          q_count = int'(cfg_count); q_min = int'(cfg_min);
          q_max = int'(cfg_max); q_mask = cfg_mask;
          m_sent = 0; m_err = 1'b0; m_stall = 0; m_dly = 0;
          if (cfg_mask == 16'h0 || cfg_count == '0 || cfg_max < cfg_min) begin
            m_err = 1'b1;
            ph    = P_FIN;
          end else begin
            issue_at = cyc + 2 + mdl_draw(q_min, q_max, l);
            ph       = P_WAIT;
          end
        end
        P_WAIT: begin
          m_dly++;
          if (cyc + 1 == issue_at) begin
            m_pay = mdl_decode(l, q_mask);
            exp_q.push_back(m_pay);
            ph = P_ISSUE;
          end
        end
        P_ISSUE: begin
          if (rdy) begin
            m_sent++;
            if (m_sent == q_count) begin
              ph = P_FIN;
            end else begin
              issue_at = cyc + 2 + mdl_draw(q_min, q_max, l);
              ph       = P_WAIT;
            end
          end else begin
            m_stall++;
          end
        end
        default: begin
          nx_done = 1'b1;
          ph      = P_IDLE;
        end
      endcase
      m_lfsr = mdl_step(l);
    end
    m_done = nx_done;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_valid) check_cycle();
    model_step();
  end

  // ---------------- driver tasks ----------------
  task automatic run_begin();
    prev_xfer_cyc = -1;
    min_gap       = 1000;
    max_gap       = -1;
    op_q.delete();
    first_seen    = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic pulse_start(input int c, input int mn, input int mx, input logic [15:0] mk);
    @(posedge clk); #1;
    cfg_count = TW'(c); cfg_min = LW'(mn); cfg_max = LW'(mx); cfg_mask = mk;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (done_cnt == d0) chk({nm, "_timeout"}, 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_act(input int budget, input string nm);
    int k;
    k = 0;
    while (!alu.ACT && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (!alu.ACT) chk({nm, "_act_timeout"}, 1'b0, 1'b1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int            x0, d0, k;
    logic [PW-1:0] r1_exp;

    // Model pins: LFSR steps and field decoding computed by hand.
    chk("pin_lfsr1", mdl_step(SEED), 32'h5670_9009);
    chk("pin_lfsr2", mdl_step(mdl_step(SEED)), 32'hAB18_4807);
    chk("pin_draw", mdl_draw(2, 5, 32'h0000_000F), 5);
    chk("pin_decode", mdl_decode(32'h0040_3300, 16'h0010),
        {4'h4, 2'h0, 8'h00, 8'h01, 8'h00, 8'hCC});

    reset_dut();
    chk("rst_busy", busy, 1'b0);
    chk("rst_sent", sent, 0);

    // 1: three back-to-back transactions, opcode 0 only, zero delay.
    rdy = 1'b1; run_begin(); x0 = xfer_cnt; d0 = done_cnt;
    pulse_start(3, 0, 0, 16'h0001);
    wait_done(100, "t1");
    repeat (4) @(posedge clk); #1;
    chk("t1_xfers", xfer_cnt - x0, 3);
    chk("t1_gap_min", min_gap, 1);
    chk("t1_gap_max", max_gap, 1);
    foreach (op_q[i]) chk("t1_op", op_q[i], 4'h0);
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_sent", sent, 3);
    chk("t1_err", err, 1'b0);

    // 2: five stall cycles in ISSUE, transfer on the sixth.
    rdy = 1'b0; run_begin(); x0 = xfer_cnt;
    pulse_start(1, 0, 0, 16'h0010);
    wait_act(50, "t2");
    repeat (5) @(posedge clk);
    #1 rdy = 1'b1;
    wait_done(20, "t2");
    chk("t2_xfers", xfer_cnt - x0, 1);
    chk("t2_stall_len", last_xfer_cyc - act_rise_cyc, 5);
    if (op_q.size() > 0) chk("t2_op", op_q[0], 4'h4);
    else chk("t2_op_seen", 1'b0, 1'b1);
    chk("t2_sent", sent, 1);
`ifdef ALU_SEQ_STATS_EN
    chk("t2_stall_cnt", stall_cnt, 5);
`endif

    // 3: 100 transactions with random delays in 2..5.
    rdy = 1'b1; run_begin(); x0 = xfer_cnt; d0 = done_cnt;
    pulse_start(100, 2, 5, 16'hA5A5);
    wait_done(2000, "t3");
    repeat (4) @(posedge clk); #1;
    chk("t3_xfers", xfer_cnt - x0, 100);
    chk("t3_gap_ge3", min_gap >= 3, 1'b1);
    chk("t3_gap_le6", max_gap <= 6, 1'b1);
    chk("t3_done_pulses", done_cnt - d0, 1);
    chk("t3_sent", sent, 100);

    // 4: empty opcode mask is rejected; next good START clears ERR.
    run_begin(); x0 = xfer_cnt;
    pulse_start(10, 0, 0, 16'h0000);
    wait_done(20, "t4");
    chk("t4_done_latency", done_cyc - start_cyc, 2);
    chk("t4_err", err, 1'b1);
    chk("t4_xfers", xfer_cnt - x0, 0);
    pulse_start(1, 0, 0, 16'h0001);
    chk("t4_err_cleared", err, 1'b0);
    wait_done(20, "t4b");

    // 5: inverted delay range and zero count are rejected.
    x0 = xfer_cnt;
    pulse_start(10, 6, 2, 16'hFFFF);
    wait_done(20, "t5a");
    chk("t5_range_err", err, 1'b1);
    pulse_start(0, 0, 0, 16'hFFFF);
    wait_done(20, "t5b");
    chk("t5_count_err", err, 1'b1);
    chk("t5_xfers", xfer_cnt - x0, 0);

    // 6: reset mid-ISSUE aborts silently; the rerun repeats the first payload.
    reset_dut();
    run_begin(); x0 = xfer_cnt;
    pulse_start(50, 0, 0, 16'hFFFF);
    k = 0;
    while ((xfer_cnt - x0 < 3 || !alu.ACT) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t6_reached_issue", alu.ACT, 1'b1);
    r1_exp = first_exp;
    d0 = done_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_act", alu.ACT, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_sent", sent, 0);
    chk("t6_rst_op", alu.OP, 4'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    chk("t6_no_done", done_cnt - d0, 0);
    run_begin();
    pulse_start(50, 0, 0, 16'hFFFF);
    k = 0;
    while (!first_seen && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t6_first_seen", first_seen, 1'b1);
    chk("t6_same_first_payload", first_obs, r1_exp);
    wait_done(400, "t6");
    chk("t6_sent", sent, 50);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
